alu_cmd_sequencer: RTL and testbench

Initiator-side front end for the team's registered 4-bit ALU tile. It buffers commands arriving on a valid/ready interface and drives the ALU operand/opcode pins one command at a time. It waits out the ALU's register latency, captures result and flags, and returns an in-order response on a valid/ready interface. It also decodes ENC results by XORing with the key and reports loop-back integrity, and it flags illegal or divide-by-zero commands.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_cmd_sequencer_if.sv | 36 +++
 rtl/alu_cmd_fifo.sv | 69 ++++++
 rtl/alu_cmd_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and payload types for the ALU command sequencer.
package alu_pkg;

  localparam int unsigned OPERAND_W = 4;
  localparam int unsigned OPCODE_W  = 4;
  localparam int unsigned RESULT_W  = 8;

  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_MUL = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_DIV = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_AND = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_OR  = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_XOR = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_NOT = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_ENC = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_NOP = 4'hF;

  localparam logic [RESULT_W-1:0] ENC_KEY_DEFAULT = 8'hAB;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic [OPCODE_W-1:0]  op;
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
  } cmd_t;

  typedef struct packed {
    logic [RESULT_W-1:0] result;
    logic                carry;
    logic                overflow;
    logic [OPCODE_W-1:0] op;
    logic                err;
    logic                enc_ok;
  } rsp_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response valid/ready bus between a requester and the ALU command sequencer.
interface alu_cmd_sequencer_if #(
  parameter int unsigned CMD_DEPTH = 4
);

  localparam int unsigned CNT_W = $clog2(CMD_DEPTH) + 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_a;
  logic [3:0]       cmd_b;
  logic [3:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_result;
  logic             rsp_carry;
  logic             rsp_overflow;
  logic [3:0]       rsp_op;
  logic             rsp_err;
  logic             rsp_enc_ok;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    input  cmd_ready, cmd_count,
    input  rsp_valid, rsp_result, rsp_carry, rsp_overflow, rsp_op, rsp_err, rsp_enc_ok
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    output cmd_ready, cmd_count,
    output rsp_valid, rsp_result, rsp_carry, rsp_overflow, rsp_op, rsp_err, rsp_enc_ok
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy, full and empty flags.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  cmd_t                   wdata,
  output cmd_t                   rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full_q;
  logic             empty_q;
  logic             push_en;
  logic             pop_en;

  assign push_en = push & ~full_q;
  assign pop_en  = pop & ~empty_q;

  always_comb begin
    count_d = count_q;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Flags are derived from the next count so they are registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues buffered commands to the registered ALU tile one at a time and returns
// captured results in order, with error and ENC loop-back integrity flags.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned ALU_LAT   = 1,
  parameter logic [7:0]  ENC_KEY   = ENC_KEY_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  alu_cmd_sequencer_if.slave      bus,
  output logic [RESULT_W-1:0]     alu_operands,
  output logic [OPCODE_W-1:0]     alu_opcode,
  input  logic [RESULT_W-1:0]     alu_result,
  input  logic                    alu_carry,
  input  logic                    alu_overflow
);

  localparam int unsigned LAT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  state_t              state_q, state_d;
  logic [LAT_W-1:0]    wait_q, wait_d;
  cmd_t                cur_q, cur_d;
  logic [RESULT_W-1:0] operands_q, operands_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  rsp_t                rsp_q, rsp_d;
  logic                rsp_valid_q, rsp_valid_d;

  cmd_t                head;
  cmd_t                wdata;
  logic                full;
  logic                empty;
  logic                pop;

  assign wdata = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};

  alu_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.cmd_valid),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .count (bus.cmd_count),
    .full  (full),
    .empty (empty)
  );

  // Next-state, issue and capture decisions; a pop always issues the head to the ALU.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    cur_d       = cur_q;
    operands_d  = operands_q;
    opcode_d    = opcode_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    pop         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!empty) pop = 1'b1;
      end
      ST_WAIT: begin
        if (wait_q == '0) begin
          rsp_d.result   = alu_result;
          rsp_d.carry    = alu_carry;
          rsp_d.overflow = alu_overflow;
          rsp_d.op       = cur_q.op;
          rsp_d.err      = (cur_q.op > OP_ENC) || ((cur_q.op == OP_DIV) && (cur_q.b == '0));
          rsp_d.enc_ok   = (cur_q.op == OP_ENC) && ((alu_result ^ ENC_KEY) == {cur_q.a, cur_q.b});
          rsp_valid_d    = 1'b1;
          state_d        = ST_RESP;
        end else begin
          wait_d = wait_q - LAT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!empty) pop = 1'b1;
          else        state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      cur_d      = head;
      operands_d = {head.a, head.b};
      opcode_d   = head.op;
      wait_d     = LAT_W'(ALU_LAT);
      state_d    = ST_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      cur_q       <= '0;
      operands_q  <= '0;
      opcode_q    <= OP_NOP;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      cur_q       <= cur_d;
      operands_q  <= operands_d;
      opcode_q    <= opcode_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign alu_operands     = operands_q;
  assign alu_opcode       = opcode_q;
  assign bus.cmd_ready    = ~full;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = rsp_q.result;
  assign bus.rsp_carry    = rsp_q.carry;
  assign bus.rsp_overflow = rsp_q.overflow;
  assign bus.rsp_op       = rsp_q.op;
  assign bus.rsp_err      = rsp_q.err;
  assign bus.rsp_enc_ok   = rsp_q.enc_ok;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: wraps a behavioural ALU tile and scoreboards every response.
module tb_alu_cmd_sequencer;

  localparam int LAT = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] alu_operands;
  logic [3:0] alu_opcode;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       alu_overflow;
  logic [9:0] alu_q;
  logic       force_bad = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  alu_cmd_sequencer_if #(.CMD_DEPTH(4)) bus ();

  alu_cmd_sequencer #(
    .CMD_DEPTH (4),
    .ALU_LAT   (LAT),
    .ENC_KEY   (8'hAB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .alu_operands (alu_operands),
    .alu_opcode   (alu_opcode),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Team ALU tile: {overflow, carry, result} for 4-bit unsigned operands.
  function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [7:0] r;
    logic       c;
    logic       v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'h0: begin s = {1'b0, a} + {1'b0, b}; r = {4'h0, s[3:0]}; c = s[4];
                  v = (a[3] == b[3]) && (s[3] != a[3]); end
      4'h1: begin s = {1'b0, a} - {1'b0, b}; r = {4'h0, s[3:0]}; c = (a < b);
                  v = (a[3] != b[3]) && (s[3] != a[3]); end
      4'h2: r = {4'h0, a} * {4'h0, b};
      4'h3: if (b != 4'h0) r = {a / b, a % b};
      4'h4: r = {4'h0, a & b};
      4'h5: r = {4'h0, a | b};
      4'h6: r = {4'h0, a ^ b};
      4'h7: r = {4'h0, ~a};
      4'h8: r = {a, b} ^ 8'hAB;
      default: r = '0;
    endcase
    return {v, c, r};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) alu_q <= '0;
    else        alu_q <= alu_fn(alu_opcode, alu_operands[7:4], alu_operands[3:0]);
  end

  assign alu_result   = force_bad ? 8'h9F : alu_q[7:0];
  assign alu_carry    = alu_q[8];
  assign alu_overflow = alu_q[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    int         push;
  } exp_t;

  exp_t        exp_q[$];
  int          last_hs = 0;
  int          prev_rise = 0;
  int          spacing_last = 0;
  int          lat_last = 0;
  int          n_rsp = 0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [15:0] prev_rsp = '0;
  logic [7:0]  last_result = '0;
  logic        last_carry = 1'b0;
  logic        last_ovf = 1'b0;
  logic        last_err = 1'b0;
  logic        last_enc = 1'b0;

  // Model: in-order queue of accepted commands; a response rises no earlier than
  // ALU_LAT+2 edges after its push and ALU_LAT+1 edges after the previous handshake.
  always @(negedge clk) begin : cmp
    exp_t        e;
    logic [9:0]  r;
    logic [7:0]  er;
    logic [15:0] cur_rsp;
    int          rise_exp;
    cur_rsp = {bus.rsp_result, bus.rsp_carry, bus.rsp_overflow, bus.rsp_op, bus.rsp_err, bus.rsp_enc_ok};
    if (!rst_n) begin
      exp_q.delete();
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      last_hs    = 0;
    end else begin
      if (prev_valid && !prev_ready) begin
        chk("stall_valid", 32'(bus.rsp_valid), 32'h1);
        chk("stall_hold", 32'(cur_rsp), 32'(prev_rsp));
      end
      if (bus.rsp_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rsp", 32'(bus.rsp_valid), 32'h0);
        end else begin
          rise_exp = exp_q[0].push + LAT + 2;
          if (last_hs + LAT + 1 > rise_exp) rise_exp = last_hs + LAT + 1;
          lat_last     = cyc - exp_q[0].push;
          spacing_last = cyc - prev_rise;
          prev_rise    = cyc;
          chk("rsp_timing", 32'(cyc), 32'(rise_exp));
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_rsp", 32'(bus.rsp_valid), 32'h0);
        end else begin
          e  = exp_q.pop_front();
          r  = alu_fn(e.op, e.a, e.b);
          er = force_bad ? 8'h9F : r[7:0];
          chk("rsp_result", 32'(bus.rsp_result), 32'(er));
          chk("rsp_carry", 32'(bus.rsp_carry), 32'(r[8]));
          chk("rsp_overflow", 32'(bus.rsp_overflow), 32'(r[9]));
          chk("rsp_op", 32'(bus.rsp_op), 32'(e.op));
          chk("rsp_err", 32'(bus.rsp_err), 32'((e.op > 4'h8) || (e.op == 4'h3 && e.b == 4'h0)));
          chk("rsp_enc_ok", 32'(bus.rsp_enc_ok), 32'((e.op == 4'h8) && ((er ^ 8'hAB) == {e.a, e.b})));
          last_result = bus.rsp_result;
          last_carry  = bus.rsp_carry;
          last_ovf    = bus.rsp_overflow;
          last_err    = bus.rsp_err;
          last_enc    = bus.rsp_enc_ok;
          last_hs     = cyc + 1;
          n_rsp++;
        end
      end
      if (bus.cmd_valid && bus.cmd_ready)
        exp_q.push_back('{bus.cmd_op, bus.cmd_a, bus.cmd_b, cyc + 1});
      prev_valid = bus.rsp_valid;
      prev_ready = bus.rsp_ready;
      prev_rsp   = cur_rsp;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    @(negedge clk);
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) chk("send_timeout", 32'(bus.cmd_ready), 32'h1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'h1);
    chk({tag, "_cmd_count"}, 32'(bus.cmd_count), 32'h0);
    chk({tag, "_operands"}, 32'(alu_operands), 32'h00);
    chk({tag, "_opcode"}, 32'(alu_opcode), 32'hF);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({tag, "_rsp_fields"}, 32'({bus.rsp_result, bus.rsp_carry, bus.rsp_overflow,
                                   bus.rsp_op, bus.rsp_err, bus.rsp_enc_ok}), 32'h0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc;
    int base;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_op    = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(4'h0, 4'd9, 4'd8);
    drain();
    chk("add_result", 32'(last_result), 32'h01);
    chk("add_carry", 32'(last_carry), 32'h1);
    chk("add_overflow", 32'(last_ovf), 32'h1);
    chk("add_err", 32'(last_err), 32'h0);
    chk("add_latency", 32'(lat_last), 32'h3);
    chk("hold_operands", 32'(alu_operands), 32'h98);
    chk("hold_opcode", 32'(alu_opcode), 32'h0);

    send(4'h2, 4'hF, 4'hF); drain();
    chk("mul_result", 32'(last_result), 32'hE1);
    send(4'h3, 4'd13, 4'd4); drain();
    chk("div_result", 32'(last_result), 32'h31);
    chk("div_err", 32'(last_err), 32'h0);
    send(4'h3, 4'd5, 4'd0); drain();
    chk("div0_result", 32'(last_result), 32'h00);
    chk("div0_err", 32'(last_err), 32'h1);
    send(4'hC, 4'd7, 4'd2); drain();
    chk("illegal_result", 32'(last_result), 32'h00);
    chk("illegal_err", 32'(last_err), 32'h1);
    send(4'h8, 4'd3, 4'd5); drain();
    chk("enc_result", 32'(last_result), 32'h9E);
    chk("enc_ok", 32'(last_enc), 32'h1);
    force_bad = 1'b1;
    send(4'h8, 4'd3, 4'd5); drain();
    force_bad = 1'b0;
    chk("enc_bad_result", 32'(last_result), 32'h9F);
    chk("enc_bad_ok", 32'(last_enc), 32'h0);

    // Backpressure: one in flight plus a full FIFO.
    bus.rsp_ready = 1'b0;
    acc  = 0;
    base = n_rsp;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 4'h0;
      bus.cmd_a     = 4'(i + 1);
      bus.cmd_b     = 4'(i);
      @(negedge clk);
      if (bus.cmd_ready) acc++;
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepted", 32'(acc), 32'h5);
    chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'h0);
    chk("bp_cmd_count", 32'(bus.cmd_count), 32'h4);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    drain();
    chk("bp_responses", 32'(n_rsp - base), 32'h5);
    chk("bp_last_result", 32'(last_result), 32'h09);

    // Streaming with the consumer always ready.
    send(4'h1, 4'd3, 4'd5);
    send(4'h6, 4'hA, 4'h5);
    send(4'h7, 4'h3, 4'h0);
    send(4'h5, 4'h9, 4'h6);
    drain();
    chk("stream_spacing", 32'(spacing_last), 32'(LAT + 2));
    chk("stream_last_result", 32'(last_result), 32'h0F);

    // Reset while a command is waiting on the ALU with two more queued.
    send(4'h0, 4'd1, 4'd2);
    send(4'h0, 4'd3, 4'd4);
    send(4'h0, 4'd5, 4'd6);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_stale_rsp", 32'(bus.rsp_valid), 32'h0);
    chk("no_stale_count", 32'(bus.cmd_count), 32'h0);
    @(posedge clk);
    #1;
    send(4'h0, 4'd1, 4'd1);
    drain();
    chk("post_rst_result", 32'(last_result), 32'h02);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
